// File: rtl/hbfir_pkg.sv
// Shared types and sizing helpers for the serial half-band FIR.
// Imported by the interface, the MAC datapath and the top level.
package hbfir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDrain,
    StRound
  } state_e;

  // Number of unique non-zero side coefficients for an NTAPS = 4*M-1 half-band.
  function automatic int unsigned m_of(input int unsigned ntaps);
    return (ntaps + 1) / 4;
  endfunction

  // Pre-add growth, M-term sum growth and the centre/rounding term.
  function automatic int unsigned aw_of(input int unsigned iw, input int unsigned tw,
                                        input int unsigned m);
    return iw + tw + 1 + $clog2(m) + 1;
  endfunction

  // Clamp a sign-extended value into the signed range of an ow-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input int unsigned ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/hbfir_serial_if.sv
// Sample/coefficient/result bundle between the sample source and the
// serial half-band filter; master drives samples and taps, slave is the filter.
interface hbfir_serial_if import hbfir_pkg::*; #(
  parameter int unsigned NTAPS = 11,
  parameter int unsigned IW    = 16,
  parameter int unsigned TW    = 12,
  parameter int unsigned OW    = 16
) ();

  localparam int unsigned KW = $clog2(m_of(NTAPS));

  logic                 i_tap_wr;
  logic [KW-1:0]        i_tap_addr;
  logic signed [TW-1:0] i_tap;
  logic                 i_ce;
  logic signed [IW-1:0] i_sample;
  logic                 o_busy;
  logic                 o_ce;
  logic signed [OW-1:0] o_result;
  logic                 o_drop;

  modport master (
    output i_tap_wr, i_tap_addr, i_tap, i_ce, i_sample,
    input  o_busy, o_ce, o_result, o_drop
  );

  modport slave (
    input  i_tap_wr, i_tap_addr, i_tap, i_ce, i_sample,
    output o_busy, o_ce, o_result, o_drop
  );

endinterface

// File: rtl/hbfir_mac.sv
// Shared datapath: symmetric pre-adder, registered multiplier and accumulator.
// The product register is cleared on load so the first MAC cycle adds nothing.
module hbfir_mac #(
  parameter int unsigned IW = 16,
  parameter int unsigned TW = 12,
  parameter int unsigned AW = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 mul_en_i,
  input  logic                 add_i,
  input  logic signed [AW-1:0] load_val_i,
  input  logic signed [IW-1:0] xa_i,
  input  logic signed [IW-1:0] xb_i,
  input  logic signed [TW-1:0] h_i,
  output logic signed [AW-1:0] acc_o
);

  localparam int unsigned PW = IW + TW + 1;

  logic signed [IW:0]    pre;
  logic signed [PW-1:0]  p_q;
  logic signed [AW-1:0]  acc_q;

  assign pre = {xa_i[IW-1], xa_i} + {xb_i[IW-1], xb_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q   <= '0;
      acc_q <= '0;
    end else begin
      if (load_i) begin
        p_q <= '0;
      end else if (mul_en_i) begin
        p_q <= PW'(pre) * PW'(h_i);
      end
      if (load_i) begin
        acc_q <= load_val_i;
      end else if (add_i) begin
        acc_q <= acc_q + AW'(p_q);
      end
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/hbfir_serial.sv
// Half-band FIR sharing one multiplier over the M unique side coefficients.
// Holds the tap line, the coefficient bank and the sequencing FSM.
module hbfir_serial import hbfir_pkg::*; #(
  parameter int unsigned NTAPS = 11,
  parameter int unsigned IW    = 16,
  parameter int unsigned TW    = 12,
  parameter int unsigned OW    = 16
) (
  input logic           i_clk,
  input logic           i_reset,
  hbfir_serial_if.slave fir_io
);

  localparam int unsigned M      = m_of(NTAPS);
  localparam int unsigned AW     = aw_of(IW, TW, M);
  localparam int unsigned KW     = $clog2(M);
  localparam int unsigned Center = (NTAPS - 1) / 2;

  logic signed [IW-1:0] x_q [NTAPS];
  logic signed [TW-1:0] h_q [M];
  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 ce_q, drop_q;
  logic signed [OW-1:0] result_q;

  logic                 busy, accept, tap_we;
  logic                 acc_load, mul_en, acc_add, round_en;
  logic signed [IW-1:0] xa, xb;
  logic signed [TW-1:0] hk;
  logic signed [AW-1:0] load_val, acc, acc_sh;
  logic signed [63:0]   sat_v;

  assign busy   = (state_q != StIdle);
  assign accept = fir_io.i_ce && !busy;
  assign tap_we = fir_io.i_tap_wr && !busy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int n = 0; n < NTAPS; n++) x_q[n] <= '0;
    end else if (accept) begin
      x_q[0] <= fir_io.i_sample;
      for (int n = 1; n < NTAPS; n++) x_q[n] <= x_q[n-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < M; k++) h_q[k] <= '0;
    end else if (tap_we) begin
      for (int k = 0; k < M; k++) begin
        if (fir_io.i_tap_addr == KW'(k)) h_q[k] <= fir_io.i_tap;
      end
    end
  end

  // Centre tap (0.5) plus the half-LSB rounding constant; the centre sample is
  // the one that lands there after this accept's shift.
  assign load_val = (AW'(x_q[Center-1]) <<< (TW - 2)) + (AW'(1) <<< (TW - 2));

  always_comb begin
    xa = '0;
    xb = '0;
    hk = '0;
    for (int k = 0; k < M; k++) begin
      if (k_q == KW'(k)) begin
        xa = x_q[2*k];
        xb = x_q[NTAPS-1-2*k];
        hk = h_q[k];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_load = 1'b0;
    mul_en   = 1'b0;
    acc_add  = 1'b0;
    round_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fir_io.i_ce) begin
          state_d  = StMac;
          k_d      = '0;
          acc_load = 1'b1;
        end
      end
      StMac: begin
        mul_en  = 1'b1;
        acc_add = 1'b1;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(M - 1)) begin
          state_d = StDrain;
          k_d     = '0;
        end
      end
      StDrain: begin
        acc_add = 1'b1;
        state_d = StRound;
      end
      StRound: begin
        round_en = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  hbfir_mac #(
    .IW (IW),
    .TW (TW),
    .AW (AW)
  ) u_mac (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .load_i     (acc_load),
    .mul_en_i   (mul_en),
    .add_i      (acc_add),
    .load_val_i (load_val),
    .xa_i       (xa),
    .xb_i       (xb),
    .h_i        (hk),
    .acc_o      (acc)
  );

  assign acc_sh = acc >>> (TW - 1);
  assign sat_v  = sat(64'(acc_sh), OW);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      ce_q     <= 1'b0;
      drop_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ce_q    <= round_en;
      drop_q  <= fir_io.i_ce && busy;
      if (round_en) result_q <= sat_v[OW-1:0];
    end
  end

  assign fir_io.o_busy   = busy;
  assign fir_io.o_ce     = ce_q;
  assign fir_io.o_result = result_q;
  assign fir_io.o_drop   = drop_q;

endmodule

// File: tb/tb_hbfir_serial.sv
// Directed bench for hbfir_serial at default parameters (M = 3, 2048 = 1.0).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hbfir_serial;

  localparam int unsigned NTAPS = 11;
  localparam int unsigned IW    = 16;
  localparam int unsigned TW    = 12;
  localparam int unsigned OW    = 16;
  localparam int unsigned M     = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hbfir_serial_if #(
    .NTAPS (NTAPS),
    .IW    (IW),
    .TW    (TW),
    .OW    (OW)
  ) fir_if ();

  hbfir_serial #(
    .NTAPS (NTAPS),
    .IW    (IW),
    .TW    (TW),
    .OW    (OW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .fir_io  (fir_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_h(input int h0, input int h1, input int h2);
    int hv[3];
    hv = '{h0, h1, h2};
    for (int k = 0; k < 3; k++) begin
      fir_if.i_tap_wr   = 1'b1;
      fir_if.i_tap_addr = 2'(k);
      fir_if.i_tap      = TW'(hv[k]);
      tick();
    end
    fir_if.i_tap_wr = 1'b0;
  endtask

  // Accept one sample and wait out the fixed latency to its o_ce cycle.
  task automatic feed(input int s, output logic signed [31:0] r);
    fir_if.i_ce     = 1'b1;
    fir_if.i_sample = IW'(s);
    tick();
    fir_if.i_ce = 1'b0;
    repeat (M + 2) tick();
    check("feed_o_ce", 32'(fir_if.o_ce), 32'sd1);
    r = 32'(fir_if.o_result);
  endtask

  int imp_exp[12] = '{16, 0, -128, 0, 1152, 1024, 1152, 0, -128, 0, 16, 0};
  int imp2_exp[11] = '{-5, 0, 64, 0, 900, 1024, 900, 0, 64, 0, -5};
  int rnd_in[3]   = '{3, -3, 1};
  int rnd_exp[3]  = '{2, -1, 1};

  initial begin
    logic signed [31:0] r;

    // Reset held with random inputs.
    rst = 1'b1;
    fir_if.i_ce       = 1'b0;
    fir_if.i_sample   = '0;
    fir_if.i_tap_wr   = 1'b0;
    fir_if.i_tap_addr = '0;
    fir_if.i_tap      = '0;
    for (int i = 0; i < 3; i++) begin
      fir_if.i_ce       = 1'($urandom);
      fir_if.i_sample   = IW'($urandom);
      fir_if.i_tap_wr   = 1'($urandom);
      fir_if.i_tap_addr = 2'($urandom_range(0, 2));
      fir_if.i_tap      = TW'($urandom);
      tick();
      check("rst_busy", 32'(fir_if.o_busy), 32'sd0);
      check("rst_ce", 32'(fir_if.o_ce), 32'sd0);
      check("rst_result", 32'(fir_if.o_result), 32'sd0);
      check("rst_drop", 32'(fir_if.o_drop), 32'sd0);
    end
    rst = 1'b0;
    fir_if.i_ce     = 1'b0;
    fir_if.i_tap_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_no_ce", 32'(fir_if.o_ce), 32'sd0);
    end

    // Impulse response.
    write_h(16, -128, 1152);
    for (int i = 0; i < 12; i++) begin
      feed((i == 0) ? 2048 : 0, r);
      check($sformatf("impulse[%0d]", i), r, 32'(imp_exp[i]));
    end

    // Latency, overrun drop and ignored busy write.
    fir_if.i_ce     = 1'b1;
    fir_if.i_sample = IW'(2048);
    tick();  // T+1
    fir_if.i_ce = 1'b0;
    check("lat_busy_t1", 32'(fir_if.o_busy), 32'sd1);
    tick();  // T+2
    check("lat_busy_t2", 32'(fir_if.o_busy), 32'sd1);
    fir_if.i_ce     = 1'b1;
    fir_if.i_sample = IW'(999);
    tick();  // T+3
    fir_if.i_ce = 1'b0;
    check("drop_t3", 32'(fir_if.o_drop), 32'sd1);
    check("lat_busy_t3", 32'(fir_if.o_busy), 32'sd1);
    fir_if.i_tap_wr   = 1'b1;
    fir_if.i_tap_addr = 2'd0;
    fir_if.i_tap      = TW'(500);
    tick();  // T+4
    fir_if.i_tap_wr = 1'b0;
    check("drop_t4", 32'(fir_if.o_drop), 32'sd0);
    check("lat_busy_t4", 32'(fir_if.o_busy), 32'sd1);
    check("lat_no_ce_t4", 32'(fir_if.o_ce), 32'sd0);
    tick();  // T+5
    check("lat_busy_t5", 32'(fir_if.o_busy), 32'sd1);
    check("lat_no_ce_t5", 32'(fir_if.o_ce), 32'sd0);
    tick();  // T+6
    check("lat_ce_t6", 32'(fir_if.o_ce), 32'sd1);
    check("lat_busy_t6", 32'(fir_if.o_busy), 32'sd0);
    check("lat_result_t6", 32'(fir_if.o_result), 32'sd16);
    tick();  // T+7
    check("lat_ce_single", 32'(fir_if.o_ce), 32'sd0);
    for (int i = 1; i < 12; i++) begin
      feed(0, r);
      check($sformatf("old_h[%0d]", i), r, 32'(imp_exp[i]));
    end

    // Saturation both ways.
    write_h(2047, 2047, 2047);
    for (int i = 0; i < 11; i++) feed(32767, r);
    check("sat_pos", r, 32'sd32767);
    for (int i = 0; i < 11; i++) feed(-32768, r);
    check("sat_neg", r, -32'sd32768);

    // Rounding through the centre tap only.
    write_h(0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      feed(rnd_in[j], r);
      for (int i = 0; i < 5; i++) feed(0, r);
      check($sformatf("round[%0d]", j), r, 32'(rnd_exp[j]));
    end

    // Reset in the middle of a computation.
    fir_if.i_ce     = 1'b1;
    fir_if.i_sample = IW'(2048);
    tick();  // T+1
    fir_if.i_ce = 1'b0;
    tick();  // T+2
    tick();  // T+3
    rst = 1'b1;
    tick();  // T+4
    rst = 1'b0;
    check("midrst_busy", 32'(fir_if.o_busy), 32'sd0);
    check("midrst_ce", 32'(fir_if.o_ce), 32'sd0);
    check("midrst_result", 32'(fir_if.o_result), 32'sd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_ce", 32'(fir_if.o_ce), 32'sd0);
    end
    write_h(-5, 64, 900);
    for (int i = 0; i < 11; i++) begin
      feed((i == 0) ? 2048 : 0, r);
      check($sformatf("impulse2[%0d]", i), r, 32'(imp2_exp[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
